param_value_sampler: RTL and testbench

- Downstream consumer of the parameter-driven constant-output modules (int output port whose default comes from a parameter `K`).
- Samples a 32-bit int source and detects value changes.
- Queues each new value into a small FIFO and presents it over a valid/ready stream to the checker logic.
- Lets elaboration tests observe parameter-derived values at runtime, not only through static drives.

---
 rtl/param_sampler_pkg.sv | 32 +++
 rtl/sampler_fifo.sv | 88 ++++++++
 rtl/param_value_sampler.sv | 139 +++++++++++++
 tb/tb_param_value_sampler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_sampler_pkg.sv
// -----------------------------------------------------------------------------
// param_sampler_pkg
//
// Purpose:
//   Shared types and constants for the parameter value sampler. Holds the
//   sampled data width, the data type carried through the FIFO, and the
//   two-state tracking FSM encoding.
//
// Contents:
//   DATA_W    - width of the sampled int value (32)
//   data_t    - logic [DATA_W-1:0]
//   state_t   - {IDLE, TRACK}, 2-bit encoded
//   is_change - full-width inequality between a new sample and the last one
// -----------------------------------------------------------------------------
package param_sampler_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1
    } state_t;

    // Plain bitwise comparison: sign and interpretation of the int are
    // irrelevant, any differing bit counts as a change.
    function automatic logic is_change(input data_t sample, input data_t last);
        return sample != last;
    endfunction

endpackage

// File: rtl/sampler_fifo.sv
// -----------------------------------------------------------------------------
// sampler_fifo
//
// Purpose:
//   Small synchronous FIFO that queues accepted sample values between the
//   change detector and the downstream consumer. The head entry is presented
//   from storage only, so a value written on an edge becomes visible in the
//   following cycle.
//
// Parameters:
//   DEPTH - number of entries, power of two, at least 2
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, empties the FIFO
//   push      in   write push_data this edge (ignored when full without pop)
//   push_data in   32-bit value to enqueue
//   pop       in   advance the head this edge (ignored when empty)
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   head      out  value at the read pointer (meaningful only when !empty)
// -----------------------------------------------------------------------------
import param_sampler_pkg::*;

module sampler_fifo #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra bit so that full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    data_t       mem_q [DEPTH];
    data_t       mem_d [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still taken when the head is leaving on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/param_value_sampler.sv
// -----------------------------------------------------------------------------
// param_value_sampler
//
// Purpose:
//   Watches a 32-bit int source (typically a module output whose value comes
//   from a parameter) and queues every new value it sees into a small FIFO,
//   presenting the queue as a valid/ready stream. The first sample after each
//   enable is always queued so the current parameter value is observable even
//   if it equals the reset value of the tracking register.
//
// Parameters:
//   K_INIT - reset value of the last-seen register
//   DEPTH  - FIFO entries, power of two, at least 2
//   CNT_W  - width of the saturating accepted-change counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   k_i        in   sampled int value
//   en_i       in   sampling enable
//   out_valid  out  FIFO head holds valid data
//   out_ready  in   consumer takes the head this cycle
//   out_data   out  FIFO head value, forced to 0 when out_valid is low
//   change_cnt out  number of values accepted into the FIFO, saturating
//   overflow   out  sticky flag: a push was dropped on a full FIFO
// -----------------------------------------------------------------------------
import param_sampler_pkg::*;

module param_value_sampler #(
    parameter int K_INIT = 0,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] k_i,
    input  logic              en_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  change_cnt,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam data_t            LAST_RST = data_t'(K_INIT);

    state_t           state_q, state_d;
    data_t            last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;

    logic  push_req;
    logic  pop_fire;
    logic  push_accept;
    logic  fifo_full;
    logic  fifo_empty;
    data_t fifo_head;

    sampler_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (k_i),
        .pop       (pop_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : fifo_head;
    assign change_cnt = cnt_q;
    assign overflow   = overflow_q;

    assign pop_fire    = out_valid && out_ready;
    assign push_accept = push_req && (!fifo_full || pop_fire);

    // Tracking FSM. IDLE primes on the first enabled cycle regardless of the
    // value; TRACK only pushes on a real change. The last-seen register
    // follows k_i whenever a push is requested, even if the FIFO drops it, so
    // a dropped value is not re-queued on the next cycle.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        push_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    push_req = 1'b1;
                    last_d   = k_i;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (is_change(k_i, last_q)) begin
                    push_req = 1'b1;
                    last_d   = k_i;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter only moves on pushes the FIFO actually took; overflow latches
    // any push that was turned away.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (push_accept && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (push_req && !push_accept) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_param_value_sampler.sv
// -----------------------------------------------------------------------------
// tb_param_value_sampler
//
// Directed bench for param_value_sampler. The stimulus process pushes the
// values it expects to see on the output stream into a queue; a monitor
// running on the falling edge pops and compares whenever a handshake is
// about to happen. Side-band outputs are checked inline by the stimulus.
// A small counter width is used so that saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_param_value_sampler;

    localparam int K_INIT = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      k_i = '0;
    logic             en_i = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] change_cnt;
    logic             overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    param_value_sampler #(
        .K_INIT (K_INIT),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .k_i        (k_i),
        .en_i       (en_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .change_cnt (change_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic applyStimulus(input logic en, input logic [31:0] k, input logic rdy);
        en_i      = en;
        k_i       = k;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkSide(input string tag, input logic [CNT_W-1:0] cnt_exp,
                             input logic ovf_exp);
        checkOutput({tag, "_change_cnt"}, 32'(change_cnt), 32'(cnt_exp));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(ovf_exp));
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        en_i      = 1'b0;
        k_i       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkSide("reset", '0, 1'b0);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_scoreboard_left"}, 32'(exp_q.size()), 32'd0);
        checkOutput({tag, "_out_valid_end"}, 32'(out_valid), 32'd0);
    endtask

    // Monitor: a handshake is decided by what is visible mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop actual=%0h required=none", out_data);
                end else begin
                    checkOutput("pop_data", out_data, exp_q.pop_front());
                end
            end
            if (!out_valid) begin
                checkOutput("idle_data_zero", out_data, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s2_k     [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
        logic        s2_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] s2_data  [5] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0};

        // Scenario 1: constant zero for five cycles queues exactly one entry.
        $display("[TB] scenario 1: prime sample");
        doReset();
        exp_q.push_back(32'd0);
        applyStimulus(1'b1, 32'd0, 1'b0);
        checkOutput("s1_valid_cycle2", 32'(out_valid), 32'd1);
        repeat (4) applyStimulus(1'b1, 32'd0, 1'b0);
        checkSide("s1", 3'd1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkDrained("s1");

        // Scenario 2: 0,0,1,1,0 with ready high emits 0,1,0 one cycle late.
        $display("[TB] scenario 2: change detection");
        doReset();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, s2_k[i], 1'b1);
            checkOutput($sformatf("s2_valid_%0d", i), 32'(out_valid), 32'(s2_valid[i]));
            checkOutput($sformatf("s2_data_%0d", i), out_data, s2_data[i]);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkSide("s2", 3'd3, 1'b0);
        checkDrained("s2");

        // Scenario 3: fill with ready low, fifth value is dropped.
        $display("[TB] scenario 3: overflow");
        doReset();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(32'(i));
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        checkSide("s3_full", 3'd4, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);
        checkSide("s3_drained", 3'd4, 1'b1);
        checkDrained("s3");

        // Scenario 4: push and pop together on a full FIFO.
        $display("[TB] scenario 4: full with simultaneous pop");
        doReset();
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'(i));
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        exp_q.push_back(32'd9);
        applyStimulus(1'b1, 32'd9, 1'b1);
        checkSide("s4_swap", 3'd5, 1'b0);
        applyStimulus(1'b1, 32'd10, 1'b0);
        checkSide("s4_still_full", 3'd5, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);
        checkDrained("s4");

        // Scenario 5: enable drop re-primes with an unchanged value.
        $display("[TB] scenario 5: re-prime");
        doReset();
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd7);
        applyStimulus(1'b1, 32'd7, 1'b1);
        applyStimulus(1'b1, 32'd7, 1'b1);
        applyStimulus(1'b0, 32'd7, 1'b1);
        applyStimulus(1'b1, 32'd7, 1'b1);
        applyStimulus(1'b1, 32'd7, 1'b1);
        applyStimulus(1'b0, 32'd7, 1'b1);
        checkSide("s5", 3'd2, 1'b0);
        checkDrained("s5");

        // Scenario 6: counter saturates instead of wrapping.
        $display("[TB] scenario 6: counter saturation");
        doReset();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(32'(10 + i));
            applyStimulus(1'b1, 32'(10 + i), 1'b1);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkSide("s6", 3'd7, 1'b0);
        checkDrained("s6");

        // Scenario 7: asynchronous reset mid-drain with three entries queued.
        $display("[TB] scenario 7: reset mid-drain");
        doReset();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(32'(i));
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("s7_residual", 32'(exp_q.size()), 32'd3);
        checkSide("s7_before", 3'd4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s7_async_valid", 32'(out_valid), 32'd0);
        checkOutput("s7_async_data", out_data, 32'd0);
        checkSide("s7_async", '0, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput("s7_last_k_init", dut.last_q, 32'(K_INIT));
        checkOutput("s7_post_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
